fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the RISC-V core, directly upstream of the main control decoder. Owns the program counter, runs a single-outstanding request/acknowledge handshake to instruction memory, and holds the IF/ID pipeline register. That register exposes the fetched instruction and its pre-split fields (opcode, func3, func7, rs1, rs2, rd) to the decoder. A one-entry skid buffer absorbs a memory response that arrives while decode is stalled, and a redirect port serves taken branches.

## Interface
Parameters:
- data_width, 32, PC/address width
- RESET_PC, 32'h0000_0000, first fetch address

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request; held with stable imem_addr until imem_ack
- imem_addr  out  data_width  fetch address (word-aligned)
- imem_ack  in  1  one-cycle response strobe; may coincide with the first cycle of imem_req
- imem_rdata  in  32  instruction, valid only while imem_ack=1
- redirect  in  1  one-cycle pulse: flush and refetch from redirect_pc
- redirect_pc  in  data_width  target; bits [1:0] ignored and forced to 0
- id_ready  in  1  decode accepts the IF/ID contents this cycle
- id_valid  out  1  IF/ID holds a live instruction
- id_pc  out  data_width  PC of id_instr
- id_instr  out  32  instruction word
- opcode  out  7  id_instr[6:0]
- rd  out  5  id_instr[11:7]
- func3  out  3  id_instr[14:12]
- rs1  out  5  id_instr[19:15]
- rs2  out  5  id_instr[24:20]
- func7  out  7  id_instr[31:25]

## Operation
- States: IDLE, FETCH, STALL, DISCARD. Reset state is IDLE.
- imem_req is high in FETCH and DISCARD, low otherwise. imem_addr equals pc in FETCH and the latched old address in DISCARD.
- IDLE → FETCH unconditionally.
- FETCH with imem_ack:
  - If the slot is free (!id_valid || id_ready): load IF/ID with {pc, rdata}, set id_valid=1, pc += 4, stay in FETCH.
  - Otherwise: write {pc, rdata} into the skid buffer, pc += 4, go to STALL.
- FETCH without imem_ack: hold pc and the request.
- STALL: when id_ready=1, move the skid contents to IF/ID (id_valid stays 1) and go to FETCH.
- Consumption: id_ready=1 with id_valid=1 and no new load clears id_valid next cycle.
- redirect has priority over every other event:
  - pc ← {redirect_pc[data_width-1:2], 2'b00}.
  - IF/ID is flushed: id_valid=0, id_instr=NOP 32'h0000_0013, fields re-derived from it.
  - The skid buffer is emptied.
  - If in FETCH with no imem_ack that cycle, go to DISCARD. Otherwise go to FETCH.
  - If imem_ack coincides with redirect, its data is dropped.
- DISCARD: hold the old request until imem_ack, drop the data, then go to FETCH at the new pc. A second redirect in DISCARD updates pc only.
- pc arithmetic is modulo 2^data_width: 0xFFFF_FFFC + 4 → 0x0000_0000.
- The field outputs are always a slicing of the registered id_instr and are never computed separately.

## Timing
- Reset values: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_pc=0, id_instr=32'h0000_0013, opcode=7'b0010011, rd=rs1=rs2=func3=func7=0. Skid is empty.
- Reset asserted mid-operation discards any outstanding request. Memory is reset on the same `rst`.
- First edge after rst falls: IDLE → FETCH. imem_req rises in that cycle.
- imem_ack in cycle N → id_valid/id_instr updated in N+1, and the next request (pc+4) is asserted in N+1.
- Peak throughput is 1 instruction/cycle with zero-wait memory and id_ready held at 1.
- redirect in cycle N → id_valid=0 in N+1. The first request to the target is in N+1, or in the cycle after the outstanding ack when the block went through DISCARD.
- There is never more than one outstanding request. No request is issued while the skid buffer is full.

## Structure
- Shared package `riscv_pkg`:
  - opcode localparams OP_RTYPE 7'b0110011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011, OP_IMM 7'b0010011
  - NOP_INSTR 32'h0000_0013
  - fetch_state_t enum {IDLE, FETCH, STALL, DISCARD}
- Sub-module `if_id_reg`: IF/ID register (pc, instr, valid) with load, flush and sync reset, plus field slicing. The FSM, pc and skid stay in fetch_stage.

## Test plan
- Reset release, zero-wait memory (ack = req), id_ready=1 → imem_addr 0,4,8,12 on consecutive cycles; id_pc 0,4,8 one cycle later; opcode=7'b0110011 for rdata 32'h0020_81B3, with rd=3, rs1=1, rs2=2.
- id_ready=0 for 3 cycles while ack arrives for addr 8 → state STALL, imem_req low. After id_ready rises, id_pc goes 4 then 8 with no instruction lost or duplicated.
- Memory latency 3 cycles, redirect to 0x100 in the second wait cycle → DISCARD, the old ack data is dropped, the next imem_addr is 0x100, and id_valid stays low until that response.
- redirect and imem_ack in the same cycle, redirect_pc=0x203 → data dropped, next imem_addr is 0x200.
- RESET_PC=32'hFFFF_FFF8, run 3 fetches → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted for 1 cycle mid-STALL → all outputs at their reset values next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcode encodings, canonical NOP and the
// fetch-stage state type.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STALL,
        DISCARD
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds pc, instruction and valid for the decoder,
// and exposes the instruction fields as plain slices of the registered word.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int unsigned data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  load_i,
    input  logic                  consume_i,
    input  logic [data_width-1:0] pc_i,
    input  logic [31:0]           instr_i,
    output logic                  valid_o,
    output logic [data_width-1:0] pc_o,
    output logic [31:0]           instr_o,
    output logic [6:0]            opcode_o,
    output logic [4:0]            rd_o,
    output logic [2:0]            func3_o,
    output logic [4:0]            rs1_o,
    output logic [4:0]            rs2_o,
    output logic [6:0]            func7_o
);

    logic                  valid_q;
    logic [data_width-1:0] pc_q;
    logic [31:0]           instr_q;

    // flush beats load, load beats consumption
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o  = valid_q;
    assign pc_o     = pc_q;
    assign instr_o  = instr_q;
    assign opcode_o = instr_q[6:0];
    assign rd_o     = instr_q[11:7];
    assign func3_o  = instr_q[14:12];
    assign rs1_o    = instr_q[19:15];
    assign rs2_o    = instr_q[24:20];
    assign func7_o  = instr_q[31:25];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, single-outstanding imem handshake,
// one-entry skid buffer and branch redirect, feeding the IF/ID register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned           data_width = 32,
    parameter logic [data_width-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [data_width-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect,
    input  logic [data_width-1:0] redirect_pc,
    input  logic                  id_ready,
    output logic                  id_valid,
    output logic [data_width-1:0] id_pc,
    output logic [31:0]           id_instr,
    output logic [6:0]            opcode,
    output logic [4:0]            rd,
    output logic [2:0]            func3,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [6:0]            func7
);

    fetch_state_t          state_q, state_d;
    logic [data_width-1:0] pc_q, pc_d;
    logic [data_width-1:0] old_addr_q, old_addr_d;
    logic [data_width-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]           skid_instr_q, skid_instr_d;

    logic                  if_load, if_flush, if_consume;
    logic [data_width-1:0] if_pc;
    logic [31:0]           if_instr;
    logic [data_width-1:0] target_pc;
    logic                  slot_free;

    assign target_pc  = redirect_pc & ~data_width'(3);
    assign slot_free  = !id_valid || id_ready;
    assign if_consume = id_valid && id_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            old_addr_q   <= RESET_PC;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            pc_q         <= pc_d;
            old_addr_q   <= old_addr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        old_addr_d   = old_addr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if_load      = 1'b0;
        if_flush     = 1'b0;
        if_pc        = pc_q;
        if_instr     = imem_rdata;
        if (redirect) begin
            // an unanswered request must still be drained before refetching
            pc_d     = target_pc;
            if_flush = 1'b1;
            if ((state_q == FETCH || state_q == DISCARD) && !imem_ack) begin
                state_d = DISCARD;
                if (state_q == FETCH) old_addr_d = pc_q;
            end else begin
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_q + data_width'(4);
                        if (slot_free) begin
                            if_load = 1'b1;
                        end else begin
                            skid_pc_d    = pc_q;
                            skid_instr_d = imem_rdata;
                            state_d      = STALL;
                        end
                    end
                end
                STALL: begin
                    if (id_ready) begin
                        if_load  = 1'b1;
                        if_pc    = skid_pc_q;
                        if_instr = skid_instr_q;
                        state_d  = FETCH;
                    end
                end
                DISCARD: if (imem_ack) state_d = FETCH;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req  = (state_q == FETCH) || (state_q == DISCARD);
        imem_addr = (state_q == DISCARD) ? old_addr_q : pc_q;
    end

    if_id_reg #(
        .data_width(data_width)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (if_flush),
        .load_i   (if_load),
        .consume_i(if_consume),
        .pc_i     (if_pc),
        .instr_i  (if_instr),
        .valid_o  (id_valid),
        .pc_o     (id_pc),
        .instr_o  (id_instr),
        .opcode_o (opcode),
        .rd_o     (rd),
        .func3_o  (func3),
        .rs1_o    (rs1),
        .rs2_o    (rs2),
        .func7_o  (func7)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle-by-cycle stimulus with a queue-based
// scoreboard checking every instruction handed to decode.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, redirect, id_ready;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack, id_valid;
    logic [31:0] imem_addr, imem_rdata, id_pc, id_instr;
    logic [6:0]  opcode, func7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3;

    logic        imem_req2, imem_ack2, id_valid2;
    logic [31:0] imem_addr2, imem_rdata2, id_pc2, id_instr2;
    logic [6:0]  opcode2, func72;
    logic [4:0]  rd2, rs12, rs22;
    logic [2:0]  func32;

    fetch_stage #(.data_width(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(id_valid),
        .id_pc(id_pc), .id_instr(id_instr), .opcode(opcode), .rd(rd),
        .func3(func3), .rs1(rs1), .rs2(rs2), .func7(func7)
    );

    fetch_stage #(.data_width(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .redirect(1'b0),
        .redirect_pc(32'h0), .id_ready(1'b1), .id_valid(id_valid2),
        .id_pc(id_pc2), .id_instr(id_instr2), .opcode(opcode2), .rd(rd2),
        .func3(func32), .rs1(rs12), .rs2(rs22), .func7(func72)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0) return 32'h0020_81B3;
        return {a[19:0], 12'h0B3};
    endfunction

    // memory model: ack after lat wait cycles of a held request
    int unsigned lat;
    logic [3:0]  wait_cnt;
    always_comb begin
        imem_ack    = imem_req && ({28'h0, wait_cnt} == lat);
        imem_rdata  = imem_ack ? memfn(imem_addr) : 32'hDEAD_BEEF;
        imem_ack2   = imem_req2;
        imem_rdata2 = imem_ack2 ? memfn(imem_addr2) : 32'hDEAD_BEEF;
    end
    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= '0;
        else                              wait_cnt <= wait_cnt + 4'd1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = memfn(pc);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && id_valid && id_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h expected no instruction", id_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_pc",     id_pc,        e.pc);
                chk("sb_instr",  id_instr,     e.instr);
                chk("sb_opcode", 32'(opcode),  32'(e.instr[6:0]));
                chk("sb_rd",     32'(rd),      32'(e.instr[11:7]));
                chk("sb_func3",  32'(func3),   32'(e.instr[14:12]));
                chk("sb_rs1",    32'(rs1),     32'(e.instr[19:15]));
                chk("sb_rs2",    32'(rs2),     32'(e.instr[24:20]));
                chk("sb_func7",  32'(func7),   32'(e.instr[31:25]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},      32'(imem_req), 32'h0);
        chk({tag, "_addr"},     imem_addr,     32'h0);
        chk({tag, "_valid"},    32'(id_valid), 32'h0);
        chk({tag, "_id_pc"},    id_pc,         32'h0);
        chk({tag, "_id_instr"}, id_instr,      32'h0000_0013);
        chk({tag, "_opcode"},   32'(opcode),   32'h13);
        chk({tag, "_fields"},   {rd, rs1, rs2, func3, func7, 7'h0}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; lat = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset("rst0");
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        push(32'h100); push(32'h200);

        cyc(); rst = 1'b0;                                   // cycle 0
        cyc(); @(negedge clk);                               // cycle 1
        chk("c1_req", 32'(imem_req), 32'h1);
        chk("c1_addr", imem_addr, 32'h0);
        chk("wrap_addr0", imem_addr2, 32'hFFFF_FFF8);
        cyc(); @(negedge clk);                               // cycle 2
        chk("c2_addr", imem_addr, 32'h4);
        chk("c2_id_pc", id_pc, 32'h0);
        chk("c2_opcode", 32'(opcode), 32'h33);
        chk("c2_rd", 32'(rd), 32'd3);
        chk("c2_rs1", 32'(rs1), 32'd1);
        chk("c2_rs2", 32'(rs2), 32'd2);
        chk("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
        cyc(); id_ready = 1'b0; @(negedge clk);              // cycle 3
        chk("c3_addr", imem_addr, 32'h8);
        chk("c3_id_pc", id_pc, 32'h4);
        chk("wrap_addr2", imem_addr2, 32'h0000_0000);
        cyc(); @(negedge clk);                               // cycle 4
        chk("stall_req", 32'(imem_req), 32'h0);
        chk("stall_id_pc", id_pc, 32'h4);
        cyc(); @(negedge clk);                               // cycle 5
        chk("stall_req2", 32'(imem_req), 32'h0);
        cyc(); id_ready = 1'b1; @(negedge clk);              // cycle 6
        chk("stall_req3", 32'(imem_req), 32'h0);
        cyc(); @(negedge clk);                               // cycle 7
        chk("unstall_addr", imem_addr, 32'hC);
        chk("unstall_id_pc", id_pc, 32'h8);
        cyc(); lat = 3; @(negedge clk);                      // cycle 8
        chk("c8_addr", imem_addr, 32'h10);
        cyc(); redirect = 1'b1; redirect_pc = 32'h100; @(negedge clk); // cycle 9
        chk("c9_valid", 32'(id_valid), 32'h0);
        cyc(); redirect = 1'b0; @(negedge clk);              // cycle 10
        chk("disc_req", 32'(imem_req), 32'h1);
        chk("disc_addr", imem_addr, 32'h10);
        chk("disc_valid", 32'(id_valid), 32'h0);
        cyc(); @(negedge clk);                               // cycle 11
        chk("disc_addr2", imem_addr, 32'h10);
        for (int k = 12; k <= 15; k++) begin
            cyc(); @(negedge clk);
            chk("redir_addr", imem_addr, 32'h100);
            chk("redir_valid", 32'(id_valid), 32'h0);
        end
        cyc(); @(negedge clk);                               // cycle 16
        chk("redir_id_valid", 32'(id_valid), 32'h1);
        chk("redir_id_pc", id_pc, 32'h100);
        chk("c16_addr", imem_addr, 32'h104);
        cyc(); cyc();                                        // cycles 17, 18
        cyc(); redirect = 1'b1; redirect_pc = 32'h203;       // cycle 19
        cyc(); redirect = 1'b0; lat = 0; @(negedge clk);     // cycle 20
        chk("coinc_addr", imem_addr, 32'h200);
        chk("coinc_valid", 32'(id_valid), 32'h0);
        cyc(); @(negedge clk);                               // cycle 21
        chk("c21_id_pc", id_pc, 32'h200);
        chk("c21_addr", imem_addr, 32'h204);
        cyc(); id_ready = 1'b0; @(negedge clk);              // cycle 22
        chk("c22_addr", imem_addr, 32'h208);
        cyc(); rst = 1'b1; @(negedge clk);                   // cycle 23
        chk("c23_stall_req", 32'(imem_req), 32'h0);
        cyc(); rst = 1'b0; id_ready = 1'b1; @(negedge clk);  // cycle 24
        check_reset("rst1");
        push(32'h0); push(32'h4);
        cyc(); @(negedge clk);                               // cycle 25
        chk("restart_req", 32'(imem_req), 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        cyc(); @(negedge clk);                               // cycle 26
        chk("restart_addr1", imem_addr, 32'h4);
        cyc(); @(negedge clk);                               // cycle 27
        chk("restart_addr2", imem_addr, 32'h8);
        cyc(); id_ready = 1'b0;                              // cycle 28
        cyc(); @(negedge clk);                               // cycle 29
        chk("sb_leftover", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
